// File: rtl/hit_led_pkg.sv
// Shared lane state encoding and counter sizing for the hit LED driver.
package hit_led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } lane_state_t;

   // One counter sized for the longest of the hold, gap and blink intervals.
   function automatic int cnt_width(input int hold, input int gap, input int blink);
      int m;
      m = hold;
      if (gap > m) m = gap;
      if (blink > m) m = blink;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hit_led_lane.sv
// One LED lane: stretches a hit pulse into a hold window with a forced off-gap on retrigger.
// LED_BLINK_EN adds a phase register that blinks the lamp during HOLD.
module hit_led_lane
   import hit_led_pkg::*;
#(
   parameter int HOLD_TICKS  = 80,
   parameter int GAP_TICKS   = 20,
   parameter int BLINK_TICKS = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic tick,
   input  logic hit,
   output logic led,
   output logic active
);

   localparam int CW = cnt_width(HOLD_TICKS, GAP_TICKS, BLINK_TICKS);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_TICKS);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_TICKS);
   localparam logic [CW-1:0] ONE     = CW'(1);

   lane_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          hold_entry;
   logic          led_d;

   // A hit always wins over a same-cycle tick; in GAP the hit is dropped.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      hold_entry = 1'b0;
      if (!en) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hit) begin
                  state_nxt  = ST_HOLD;
                  cnt_nxt    = HOLD_LD;
                  hold_entry = 1'b1;
               end
            end
            ST_HOLD: begin
               if (hit) begin
                  if (GAP_TICKS == 0) begin
                     cnt_nxt    = HOLD_LD;
                     hold_entry = 1'b1;
                  end else begin
                     state_nxt = ST_GAP;
                     cnt_nxt   = GAP_LD;
                  end
               end else if (tick) begin
                  if (cnt == ONE) begin
                     state_nxt = ST_IDLE;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt - ONE;
                  end
               end
            end
            ST_GAP: begin
               if (tick) begin
                  if (cnt == ONE) begin
                     state_nxt  = ST_HOLD;
                     cnt_nxt    = HOLD_LD;
                     hold_entry = 1'b1;
                  end else begin
                     cnt_nxt = cnt - ONE;
                  end
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

`ifdef LED_BLINK_EN
   localparam logic [CW-1:0] BLINK_LD = CW'(BLINK_TICKS);

   logic          phase, phase_nxt;
   logic [CW-1:0] bcnt, bcnt_nxt;

   // Phase restarts lit on every HOLD entry so each window begins visibly on.
   always_comb begin
      phase_nxt = phase;
      bcnt_nxt  = bcnt;
      if (hold_entry) begin
         phase_nxt = 1'b1;
         bcnt_nxt  = BLINK_LD;
      end else if (state == ST_HOLD && state_nxt == ST_HOLD && tick) begin
         if (bcnt == ONE) begin
            phase_nxt = ~phase;
            bcnt_nxt  = BLINK_LD;
         end else begin
            bcnt_nxt = bcnt - ONE;
         end
      end
      led_d = (state_nxt == ST_HOLD) && phase_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= 1'b0;
         bcnt  <= '0;
      end else begin
         phase <= phase_nxt;
         bcnt  <= bcnt_nxt;
      end
   end
`else
   assign led_d = (state_nxt == ST_HOLD);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         led   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         led   <= led_d;
      end
   end

   assign active = (state_nxt != ST_IDLE);

endmodule

// File: rtl/hit_led_driver.sv
// Hit-to-LED driver: shared tick prescaler, NUM_CH independent lanes, registered busy.
// Optional blink mode is enabled by defining LED_BLINK_EN.
module hit_led_driver
   import hit_led_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int TICK_DIV    = 100000,
   parameter int HOLD_TICKS  = 80,
   parameter int GAP_TICKS   = 20,
   parameter int BLINK_TICKS = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] hit,
   output logic [NUM_CH-1:0] led,
   output logic              busy
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic              tick;
   logic [NUM_CH-1:0] active;

   if (TICK_DIV == 1) begin : g_nodiv
      assign tick = 1'b1;
   end else begin : g_div
      localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] pcnt;

      // Held at 0 while disabled so enabling always starts a full tick period.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)               pcnt <= '0;
         else if (!en)          pcnt <= '0;
         else if (pcnt == LAST) pcnt <= '0;
         else                   pcnt <= pcnt + PW'(1);
      end

      assign tick = (pcnt == LAST);
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      hit_led_lane #(
         .HOLD_TICKS (HOLD_TICKS),
         .GAP_TICKS  (GAP_TICKS),
         .BLINK_TICKS(BLINK_TICKS)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .tick  (tick),
         .hit   (hit[i]),
         .led   (led[i]),
         .active(active[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= 1'b0;
      else     busy <= |active;
   end

endmodule

// File: tb/tb_hit_led_driver.sv
// Bench for hit_led_driver: directed table, multi-cycle corner sequences, and a
// randomized run against a tick-timestamp reference model. Follows LED_BLINK_EN if defined.
module tb_hit_led_driver;

   localparam int N  = 4;
   localparam int NI = 4;

   // Instance configurations: A, B (no gap), C (divided tick), D (blink demo).
   localparam int TD_A = 1, HL_A = 3, GP_A = 2, BL_A = 15;
   localparam int TD_B = 1, HL_B = 3, GP_B = 0, BL_B = 15;
   localparam int TD_C = 4, HL_C = 2, GP_C = 1, BL_C = 15;
   localparam int TD_D = 1, HL_D = 6, GP_D = 2, BL_D = 2;

   logic                   clk, rst, en;
   logic [NI-1:0][N-1:0]   hit;
   logic [NI-1:0][N-1:0]   led;
   logic [NI-1:0]          busy;

   hit_led_driver #(.NUM_CH(N), .TICK_DIV(TD_A), .HOLD_TICKS(HL_A), .GAP_TICKS(GP_A), .BLINK_TICKS(BL_A))
      dut_a (.clk(clk), .rst(rst), .en(en), .hit(hit[0]), .led(led[0]), .busy(busy[0]));
   hit_led_driver #(.NUM_CH(N), .TICK_DIV(TD_B), .HOLD_TICKS(HL_B), .GAP_TICKS(GP_B), .BLINK_TICKS(BL_B))
      dut_b (.clk(clk), .rst(rst), .en(en), .hit(hit[1]), .led(led[1]), .busy(busy[1]));
   hit_led_driver #(.NUM_CH(N), .TICK_DIV(TD_C), .HOLD_TICKS(HL_C), .GAP_TICKS(GP_C), .BLINK_TICKS(BL_C))
      dut_c (.clk(clk), .rst(rst), .en(en), .hit(hit[2]), .led(led[2]), .busy(busy[2]));
   hit_led_driver #(.NUM_CH(N), .TICK_DIV(TD_D), .HOLD_TICKS(HL_D), .GAP_TICKS(GP_D), .BLINK_TICKS(BL_D))
      dut_d (.clk(clk), .rst(rst), .en(en), .hit(hit[3]), .led(led[3]), .busy(busy[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int p_td(input int k);
      case (k) 0: return TD_A; 1: return TD_B; 2: return TD_C; default: return TD_D; endcase
   endfunction
   function automatic int p_hl(input int k);
      case (k) 0: return HL_A; 1: return HL_B; 2: return HL_C; default: return HL_D; endcase
   endfunction
   function automatic int p_gp(input int k);
      case (k) 0: return GP_A; 1: return GP_B; 2: return GP_C; default: return GP_D; endcase
   endfunction
   function automatic int p_bl(input int k);
      case (k) 0: return BL_A; 1: return BL_B; 2: return BL_C; default: return BL_D; endcase
   endfunction

   // Reference model: each lane remembers the tick index at which its current
   // window started and the tick index at which it ends.
   int m_pc [NI];
   int m_tk [NI];
   bit m_on [NI][N];
   bit m_gap[NI][N];
   int m_start[NI][N];
   int m_end  [NI][N];

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_pc[k] = 0;
         m_tk[k] = 0;
         for (int l = 0; l < N; l++) begin
            m_on[k][l] = 0; m_gap[k][l] = 0; m_start[k][l] = 0; m_end[k][l] = 0;
         end
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NI; k++) begin
         if (!en) begin
            m_pc[k] = 0;
            for (int l = 0; l < N; l++) begin m_on[k][l] = 0; m_gap[k][l] = 0; end
         end else begin
            if (m_pc[k] == p_td(k) - 1) m_tk[k]++;
            m_pc[k] = (m_pc[k] + 1) % p_td(k);
            for (int l = 0; l < N; l++) begin
               if (hit[k][l] && !m_gap[k][l]) begin
                  if (m_on[k][l] && p_gp(k) > 0) begin
                     m_on[k][l] = 0; m_gap[k][l] = 1; m_end[k][l] = m_tk[k] + p_gp(k);
                  end else begin
                     m_on[k][l] = 1; m_start[k][l] = m_tk[k]; m_end[k][l] = m_tk[k] + p_hl(k);
                  end
               end else if (m_tk[k] == m_end[k][l]) begin
                  if (m_gap[k][l]) begin
                     m_gap[k][l] = 0; m_on[k][l] = 1;
                     m_start[k][l] = m_tk[k]; m_end[k][l] = m_tk[k] + p_hl(k);
                  end else begin
                     m_on[k][l] = 0;
                  end
               end
            end
         end
      end
   endtask

   function automatic logic [N-1:0] model_led(input int k);
      logic [N-1:0] v;
      v = '0;
      for (int l = 0; l < N; l++) begin
`ifdef LED_BLINK_EN
         v[l] = m_on[k][l] && ((((m_tk[k] - m_start[k][l]) / p_bl(k)) % 2) == 0);
`else
         v[l] = m_on[k][l];
`endif
      end
      return v;
   endfunction

   function automatic logic model_busy(input int k);
      logic b;
      b = 1'b0;
      for (int l = 0; l < N; l++) b = b | m_on[k][l] | m_gap[k][l];
      return b;
   endfunction

   int n_chk, n_pass;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Counts lit cycles of one lane starting from the cycle just after a hit edge.
   task automatic measure(input int k, input int l, output int len);
      len = 0;
      while (led[k][l] && len < 20) begin
         len++;
         step();
      end
   endtask

   typedef struct {
      logic [N-1:0] ha, hb;
      logic [N-1:0] la, lb;
      logic         ya, yb;
   } vec_t;

   vec_t tbl[10];
   int   len;
   logic [6:0] dpat;

   initial begin
      n_chk = 0;
      n_pass = 0;
      tbl[0] = '{4'b0101, 4'b0010, 4'b0101, 4'b0010, 1'b1, 1'b1};
      tbl[1] = '{4'b0000, 4'b0000, 4'b0101, 4'b0010, 1'b1, 1'b1};
      tbl[2] = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 1'b1, 1'b1};
      tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1};
      tbl[4] = '{4'b0000, 4'b0000, 4'b0100, 4'b0010, 1'b1, 1'b1};
      tbl[5] = '{4'b1010, 4'b0000, 4'b1110, 4'b0000, 1'b1, 1'b0};
      tbl[6] = '{4'b0000, 4'b1000, 4'b1110, 4'b1000, 1'b1, 1'b1};
      tbl[7] = '{4'b0000, 4'b0000, 4'b1010, 4'b1000, 1'b1, 1'b1};
      tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1};
      tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

      rst = 1'b1; en = 1'b0; hit = '0;
      model_reset();
      repeat (3) step();
      for (int k = 0; k < NI; k++) begin
         check($sformatf("reset_led%0d", k), led[k], '0);
         check($sformatf("reset_busy%0d", k), busy[k], '0);
      end
      rst = 1'b0; en = 1'b1;

      // Directed table on A (gap) and B (restart).
      for (int i = 0; i < 10; i++) begin
         hit[0] = tbl[i].ha;
         hit[1] = tbl[i].hb;
         step();
         check($sformatf("tbl%0d_led_a", i), led[0], tbl[i].la);
         check($sformatf("tbl%0d_led_b", i), led[1], tbl[i].lb);
         check($sformatf("tbl%0d_busy_a", i), busy[0], tbl[i].ya);
         check($sformatf("tbl%0d_busy_b", i), busy[1], tbl[i].yb);
      end
      hit = '0;

      // Divided tick: on-length depends on prescaler phase at the hit.
      for (int p = 0; p < TD_C; p++) begin
         for (int g = 0; g < 10 && m_pc[2] != p; g++) step();
         hit[2] = 4'b0001;
         step();
         hit[2] = '0;
         measure(2, 0, len);
         check($sformatf("c_len_phase%0d", p), len, (p == TD_C - 1) ? 8 : 7 - p);
         check($sformatf("c_range_phase%0d", p), (len >= 5 && len <= 8), 1);
      end

      // Asynchronous reset in the middle of a hold window.
      hit[0] = 4'b0001;
      step();
      hit[0] = '0;
      check("pre_rst_led", led[0], 4'b0001);
      #2 rst = 1'b1;
      #1;
      check("rst_async_led", led[0], '0);
      check("rst_async_busy", busy[0], '0);
      model_reset();
      step();
      rst = 1'b0;
      step();
      check("post_rst_led", led[0], '0);
      check("post_rst_busy", busy[0], '0);

      // Enable low kills a window and masks hits.
      hit[0] = 4'b0001;
      step();
      hit[0] = '0;
      check("pre_en_led", led[0], 4'b0001);
      en = 1'b0;
      step();
      check("en_low_led", led[0], '0);
      check("en_low_busy", busy[0], '0);
      hit = '1;
      repeat (2) begin
         step();
         check("en_low_hit_led", led[0], '0);
         check("en_low_hit_led_c", led[2], '0);
         check("en_low_hit_busy", busy[0], '0);
      end
      hit = '0;
      en = 1'b1;
      hit[2] = 4'b0010;
      step();
      hit[2] = '0;
      measure(2, 1, len);
      check("en_rise_presc_len", len, 7);

      // All four lanes of D hit together.
`ifdef LED_BLINK_EN
      dpat = 7'b0110011;
`else
      dpat = 7'b0111111;
`endif
      hit[3] = 4'b1111;
      step();
      hit[3] = '0;
      for (int j = 0; j < 7; j++) begin
         check($sformatf("d_led_row%0d", j), led[3], {N{dpat[j]}});
         check($sformatf("d_busy_row%0d", j), busy[3], (j < HL_D) ? 1 : 0);
         step();
      end

      // Randomized run against the model; hits avoid lanes currently in the gap.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NI; k++)
            for (int l = 0; l < N; l++)
               hit[k][l] = ($urandom_range(0, 7) == 0) && !m_gap[k][l];
         en = ($urandom_range(0, 49) != 0);
         step();
         for (int k = 0; k < NI; k++) begin
            check($sformatf("rnd%0d_led%0d", c, k), led[k], model_led(k));
            check($sformatf("rnd%0d_busy%0d", c, k), busy[k], model_busy(k));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
